// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staggered multi-domain reset sequencer with cold/warm sources and sticky cause register
// Optional watchdog warm-reset source: define RESET_SEQ_WDOG_EN.
`timescale 1ns/1ps
module reset_seq #(
    parameter int NUM_DOMAINS     = 2,
    parameter int CTR_W           = 8,
    parameter int BASE_DLY        = 245,
    parameter int STAGGER_DLY     = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WDOG_CYCLES     = 65535
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BTN_RESET,
    input  logic                   PLL_LOCKED,
    input  logic                   SYSRESETREQ,
    input  logic                   WDOG_KICK,
    input  logic                   CAUSE_CLR,
    output logic [NUM_DOMAINS-1:0] RESETn,
    output logic                   RST_ACTIVE,
    output logic [4:0]             RST_CAUSE
);

    localparam int LAST_I = BASE_DLY + (NUM_DOMAINS - 1) * STAGGER_DLY;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_WARM  = 2'd3;

    localparam logic [CTR_W-1:0]       CNT_T0       = CTR_W'(BASE_DLY);
    localparam logic [CTR_W-1:0]       CNT_LAST     = CTR_W'(LAST_I);
    localparam logic [DB_W-1:0]        DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] WARM_PATTERN = NUM_DOMAINS'(1);

    if (NUM_DOMAINS < 2) begin : g_bad_domains
        $error("reset_seq: NUM_DOMAINS must be at least 2");
    end
    if (LAST_I >= (2 ** CTR_W)) begin : g_bad_ctr_w
        $error("reset_seq: last release time does not fit in CTR_W bits");
    end
    if (DEBOUNCE_CYCLES < 1 || WDOG_CYCLES < 2) begin : g_bad_timing
        $error("reset_seq: DEBOUNCE_CYCLES must be >= 1 and WDOG_CYCLES >= 2");
    end

    logic [1:0]             state, state_nxt;
    logic [CTR_W-1:0]       cnt, cnt_nxt;
    logic                   warm_seq, warm_nxt;
    logic                   btn_s1, btn_s2, pll_s1, pll_s2;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt;
    logic [NUM_DOMAINS-1:0] rstn_nxt;
    logic [4:0]             cause_set;
    logic                   cold;
    logic                   wd_fire;

    // RESET itself is handled by the synchronous reset branch below.
    assign cold = btn_db | ~pll_s2;

`ifdef RESET_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = (state == ST_RUN) && !WDOG_KICK && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK) begin
        if (RESET || (state != ST_RUN) || WDOG_KICK) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_wdog_kick;
    assign unused_wdog_kick = WDOG_KICK;
    assign wd_fire          = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        warm_nxt  = warm_seq;
        rstn_nxt  = RESETn;
        cause_set = 5'b0;
        case (state)
            ST_HOLD: begin
                rstn_nxt  = '0;
                cnt_nxt   = '0;
                warm_nxt  = 1'b0;
                state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    rstn_nxt[i] = (cnt >= CTR_W'(BASE_DLY + i * STAGGER_DLY));
                end
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
                // Only a warm-started sequence may be pushed back into WARM.
                if (warm_seq && SYSRESETREQ) begin
                    state_nxt    = ST_WARM;
                    rstn_nxt     = WARM_PATTERN;
                    cause_set[3] = 1'b1;
                end
            end
            ST_RUN: begin
                rstn_nxt = '1;
                if (SYSRESETREQ || wd_fire) begin
                    state_nxt    = ST_WARM;
                    rstn_nxt     = WARM_PATTERN;
                    cause_set[3] = SYSRESETREQ;
                    cause_set[4] = wd_fire;
                end
            end
            default: begin
                rstn_nxt = WARM_PATTERN;
                if (!SYSRESETREQ) begin
                    state_nxt = ST_COUNT;
                    cnt_nxt   = CNT_T0;
                    warm_nxt  = 1'b1;
                end
            end
        endcase
        if (cold) begin
            if (state != ST_HOLD) begin
                cause_set = {2'b00, btn_db, ~pll_s2, 1'b0};
            end
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
            warm_nxt  = 1'b0;
            rstn_nxt  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            warm_seq   <= 1'b0;
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            // Lock synchroniser clears to "locked" so a stable PLL adds no start-up latency.
            pll_s1     <= 1'b1;
            pll_s2     <= 1'b1;
            btn_db     <= 1'b0;
            db_cnt     <= '0;
            RESETn     <= '0;
            RST_ACTIVE <= 1'b1;
            RST_CAUSE  <= 5'b00001;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            warm_seq   <= warm_nxt;
            btn_s1     <= BTN_RESET;
            btn_s2     <= btn_s1;
            pll_s1     <= PLL_LOCKED;
            pll_s2     <= pll_s1;
            RESETn     <= rstn_nxt;
            RST_ACTIVE <= ~&rstn_nxt;
            RST_CAUSE  <= (CAUSE_CLR ? 5'b0 : RST_CAUSE) | cause_set;
            if (btn_s2 != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// tb/tb_reset_seq.sv - self-checking bench for reset_seq against a time-based behavioural model
`timescale 1ns/1ps
module tb_reset_seq;

    localparam int ND   = 2;
    localparam int T0   = 245;
    localparam int STG  = 10;
    localparam int LAST = T0 + (ND - 1) * STG;
    localparam int DEB  = 16;
    localparam int WDC  = 100;
`ifdef RESET_SEQ_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET, BTN_RESET, PLL_LOCKED, SYSRESETREQ, WDOG_KICK, CAUSE_CLR;
    logic [ND-1:0] RESETn;
    logic          RST_ACTIVE;
    logic [4:0]    RST_CAUSE;

    int tests = 0;
    int fails = 0;

    reset_seq #(.NUM_DOMAINS(ND), .WDOG_CYCLES(WDC)) dut (
        .CLK(CLK), .RESET(RESET), .BTN_RESET(BTN_RESET), .PLL_LOCKED(PLL_LOCKED),
        .SYSRESETREQ(SYSRESETREQ), .WDOG_KICK(WDOG_KICK), .CAUSE_CLR(CAUSE_CLR),
        .RESETn(RESETn), .RST_ACTIVE(RST_ACTIVE), .RST_CAUSE(RST_CAUSE)
    );

    always #5 CLK = ~CLK;

    // Model: domain i is released T_i+1 edges after the sequence origin edge.
    int            cyc = 0;
    bit            m_valid = 1'b0;
    bit            m_hold, m_warm, m_wseq, m_cold, m_run, m_fire;
    int            m_origin, m_dbrun, m_wd;
    bit [1:0]      m_btn_p, m_pll_p;
    bit            m_db;
    logic [4:0]    m_set;
    logic [ND-1:0] exp_rstn;
    logic [4:0]    exp_cause;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            m_valid = 1'b1; m_hold = 1'b1; m_warm = 1'b0; m_wseq = 1'b0; m_origin = 0;
            m_btn_p = 2'b00; m_pll_p = 2'b11; m_db = 1'b0; m_dbrun = 0; m_wd = 0;
            exp_rstn = '0; exp_cause = 5'b00001;
        end else if (m_valid) begin
            m_cold = m_db || !m_pll_p[1];
            m_run  = !m_hold && !m_warm && (cyc > m_origin + LAST + 1);
            m_fire = WD_EN && m_run && !WDOG_KICK && (m_wd == WDC - 1);
            m_set  = 5'b0;
            if (m_cold) begin
                if (!m_hold) m_set = {2'b00, m_db, !m_pll_p[1], 1'b0};
                m_hold = 1'b1; m_warm = 1'b0; m_wseq = 1'b0; exp_rstn = '0;
            end else if (m_hold) begin
                m_hold = 1'b0; m_origin = cyc; m_wseq = 1'b0; exp_rstn = '0;
            end else if (m_warm) begin
                exp_rstn = ND'(1);
                if (!SYSRESETREQ) begin
                    m_warm = 1'b0; m_wseq = 1'b1; m_origin = cyc - T0;
                end
            end else if ((m_run && (SYSRESETREQ || m_fire)) || (!m_run && m_wseq && SYSRESETREQ)) begin
                m_warm = 1'b1; m_set[3] = SYSRESETREQ; m_set[4] = m_fire; exp_rstn = ND'(1);
            end else begin
                for (int i = 0; i < ND; i++) exp_rstn[i] = (cyc >= m_origin + T0 + i * STG + 1);
            end
            exp_cause = (CAUSE_CLR ? 5'b0 : exp_cause) | m_set;
            m_wd = (m_run && !WDOG_KICK) ? m_wd + 1 : 0;
            if (m_btn_p[1] != m_db) begin
                m_dbrun++;
                if (m_dbrun == DEB) begin
                    m_db = m_btn_p[1]; m_dbrun = 0;
                end
            end else begin
                m_dbrun = 0;
            end
            m_btn_p = {m_btn_p[0], BTN_RESET};
            m_pll_p = {m_pll_p[0], PLL_LOCKED};
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            tests++;
            if (RESETn !== exp_rstn || RST_ACTIVE !== (exp_rstn != '1) || RST_CAUSE !== exp_cause) begin
                fails++;
                $display("FAIL model_cycle_%0d: RESETn=%b RST_ACTIVE=%b RST_CAUSE=%b, required %b %b %b",
                         cyc, RESETn, RST_ACTIVE, RST_CAUSE, exp_rstn, (exp_rstn != '1), exp_cause);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_for(input logic [ND-1:0] mask, input logic [ND-1:0] val,
                            input int limit, output int steps);
        steps = -1;
        for (int k = 1; k <= limit && steps < 0; k++) begin
            step();
            if ((RESETn & mask) === (val & mask)) steps = k;
        end
    endtask

    task automatic pulse_clr();
        CAUSE_CLR = 1'b1;
        step();
        CAUSE_CLR = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        bit flag;
        RESET = 1'b1; BTN_RESET = 1'b0; PLL_LOCKED = 1'b1;
        SYSRESETREQ = 1'b0; WDOG_KICK = 1'b0; CAUSE_CLR = 1'b0;
        repeat (3) step();
        check("reset_rstn", int'(RESETn), 0);
        check("reset_cause", int'(RST_CAUSE), 5'b00001);
        RESET = 1'b0;

        wait_for(2'b01, 2'b01, 400, s);
        check("por_dom0_edges", s - 1, 246);
        check("por_active_before_dom1", int'(RST_ACTIVE), 1);
        wait_for(2'b10, 2'b10, 40, s);
        check("por_dom1_stagger", s, 10);
        check("por_active_low", int'(RST_ACTIVE), 0);
        check("por_cause", int'(RST_CAUSE), 5'b00001);

        SYSRESETREQ = 1'b1;
        step();
        check("warm_entry", int'(RESETn), 2'b01);
        flag = 1'b0;
        repeat (4) begin
            step();
            if (RESETn[0] !== 1'b1) flag = 1'b1;
        end
        SYSRESETREQ = 1'b0;
        s = -1;
        for (int k = 1; k <= 40 && s < 0; k++) begin
            step();
            if (RESETn[0] !== 1'b1) flag = 1'b1;
            if (RESETn[1] === 1'b1) s = k;
        end
        check("warm_dom1_edges", s - 1, 11);
        check("warm_dom0_held", int'(flag), 0);
        check("warm_cause", int'(RST_CAUSE), 5'b01001);

        pulse_clr();
        check("clr_in_run", int'(RST_CAUSE), 0);
        CAUSE_CLR = 1'b1; SYSRESETREQ = 1'b1;
        step();
        CAUSE_CLR = 1'b0;
        check("clr_vs_sysreq", int'(RST_CAUSE), 5'b01000);
        step();
        SYSRESETREQ = 1'b0;
        wait_for(2'b11, 2'b11, 40, s);
        check("warm_rerelease_found", int'(s > 0), 1);

        pulse_clr();
        BTN_RESET = 1'b1;
        repeat (8) step();
        BTN_RESET = 1'b0;
        flag = 1'b0;
        repeat (30) begin
            step();
            if (RESETn !== 2'b11) flag = 1'b1;
        end
        check("btn_glitch_ignored", int'(flag), 0);
        BTN_RESET = 1'b1;
        wait_for(2'b11, 2'b00, 30, s);
        check("btn_assert_edges", s, 19);
        repeat (40 - s) step();
        BTN_RESET = 1'b0;
        check("btn_cause", int'(RST_CAUSE), 5'b00100);
        pulse_clr();
        wait_for(2'b01, 2'b01, 400, s);
        check("btn_seq_dom0_edges", s + 1, 265);

        repeat (4) step();
        PLL_LOCKED = 1'b0;
        wait_for(2'b11, 2'b00, 10, s);
        check("pll_loss_edges", s, 3);
        check("pll_cause", int'(RST_CAUSE), 5'b00010);
        repeat (20) step();
        PLL_LOCKED = 1'b1;
        wait_for(2'b01, 2'b01, 400, s);
        check("pll_relock_dom0_edges", s, 249);
        wait_for(2'b10, 2'b10, 40, s);
        check("pll_relock_dom1", s, 10);

`ifdef RESET_SEQ_WDOG_EN
        wait_for(2'b11, 2'b01, 200, s);
        check("wdog_fire_edges", s, 100);
        check("wdog_cause", int'(RST_CAUSE), 5'b10010);
        wait_for(2'b11, 2'b11, 40, s);
        check("wdog_rerelease_found", int'(s > 0), 1);
        flag = 1'b0;
        repeat (20) begin
            WDOG_KICK = 1'b1;
            step();
            WDOG_KICK = 1'b0;
            if (RESETn !== 2'b11) flag = 1'b1;
            repeat (49) begin
                step();
                if (RESETn !== 2'b11) flag = 1'b1;
            end
        end
        check("wdog_kicked_no_reset", int'(flag), 0);
`endif

        for (int n = 0; n < 20000; n++) begin
            if (BTN_RESET) begin
                if ($urandom_range(0, 29) == 0) BTN_RESET = 1'b0;
            end else if ($urandom_range(0, 399) == 0) BTN_RESET = 1'b1;
            if (PLL_LOCKED) begin
                if ($urandom_range(0, 1499) == 0) PLL_LOCKED = 1'b0;
            end else if ($urandom_range(0, 49) == 0) PLL_LOCKED = 1'b1;
            if (SYSRESETREQ) begin
                if ($urandom_range(0, 7) == 0) SYSRESETREQ = 1'b0;
            end else if ($urandom_range(0, 119) == 0) SYSRESETREQ = 1'b1;
            RESET     = ($urandom_range(0, 2999) == 0);
            CAUSE_CLR = ($urandom_range(0, 63) == 0);
            WDOG_KICK = ($urandom_range(0, 79) == 0);
            step();
        end
        RESET = 1'b0; CAUSE_CLR = 1'b0; WDOG_KICK = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
